// File: rtl/seq_mem_arbiter.sv
// Shares one single-port memory between the fetch port and the load/store port.
// Ack arrives MEM_LAT+2 cycles after a request is granted from IDLE.
// Requesters stall by holding req until their one-cycle ack; one access is in flight at a time.
module seq_mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              own_q;   // 1 = data port owns the access
  logic              last_q;  // 1 = data port was granted last
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              if_ack_q, d_ack_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  logic if_elig, d_elig, grant, sel_d, done;

  // A port's req during its own ack cycle is still the old request, so it is masked.
  assign if_elig = if_req & ~if_ack_q;
  assign d_elig  = d_req & ~d_ack_q;
  assign grant   = if_elig | d_elig;
  assign sel_d   = d_elig & (~if_elig | ~last_q);
  assign done    = (state_q == S_WAIT) && (cnt_q == 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en = (state_q == S_ISSUE);
    mem_we = (state_q == S_ISSUE) & we_q;
    busy   = (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      own_q      <= 1'b0;
      last_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if_ack_q <= done & ~own_q;
      d_ack_q  <= done & own_q;
      if (state_q == S_IDLE && grant) begin
        own_q   <= sel_d;
        last_q  <= sel_d;
        we_q    <= sel_d & d_we;
        addr_q  <= sel_d ? d_addr : if_addr;
        wdata_q <= d_wdata;
      end
      if (state_q == S_ISSUE) cnt_q <= LAT;
      else if (state_q == S_WAIT) cnt_q <= cnt_q - 4'd1;
      if (done && !own_q) if_rdata_q <= mem_rdata;
      if (done && own_q && !we_q) d_rdata_q <= mem_rdata;
    end
  end

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_seq_mem_arbiter.sv
// Bench for seq_mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level timing and memory model.
module tb_seq_mem_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [63:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [63:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, mem_en, mem_we, busy;

  logic        if_req1, d_req1, d_we1;
  logic [63:0] if_addr1, d_addr1, d_wdata1, mem_rdata1;
  logic [63:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic        if_ack1, d_ack1, mem_en1, mem_we1, busy1;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] mem [logic [63:0]];
  logic [63:0] refmem [8];
  int          cd;
  logic [63:0] pend;
  logic        en1_prev;

  always #5 clk = ~clk;

  seq_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  seq_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_rdata(d_rdata1), .d_ack(d_ack1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  // Memory: data for an access seen in cycle c is driven in cycle c+LAT, junk otherwise.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd = 0;
      mem_rdata = '0;
    end else begin
      if (cd > 0) begin
        cd--;
        mem_rdata = (cd == 0) ? pend : {$urandom, $urandom};
      end else begin
        mem_rdata = {$urandom, $urandom};
      end
      if (mem_en) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        else pend = mem.exists(mem_addr) ? mem[mem_addr] : 64'd0;
        cd = LAT;
      end
    end
  end

  always @(negedge clk) begin
    mem_rdata1 = en1_prev ? 64'h00500093 : {$urandom, $urandom};
    en1_prev = mem_en1;
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_txn(input logic is_d, input logic we, input logic [63:0] a,
                         input logic [63:0] w, input int drop_at,
                         output int en_c, output int ack_c, output int n_en, output int n_ack,
                         output int n_oth, output int busy_n, output logic en_we,
                         output logic [63:0] en_addr, output logic [63:0] en_wdata,
                         output logic [63:0] rd);
    en_c = -1; ack_c = -1; n_en = 0; n_ack = 0; n_oth = 0; busy_n = 0;
    en_we = 1'bx; en_addr = 'x; en_wdata = 'x; rd = 'x;
    @(negedge clk);
    if (is_d) begin d_req = 1; d_we = we; d_addr = a; d_wdata = w; end
    else begin if_req = 1; if_addr = a; end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_en) begin
        n_en++; en_c = k; en_we = mem_we; en_addr = mem_addr; en_wdata = mem_wdata;
      end
      if (busy) busy_n++;
      if (is_d ? d_ack : if_ack) begin
        n_ack++; ack_c = k; rd = is_d ? d_rdata : if_rdata;
        if (is_d) d_req = 0; else if_req = 0;
      end
      if (is_d ? if_ack : d_ack) n_oth++;
      if (k == drop_at) begin
        if (is_d) begin d_req = 0; d_addr = ~a; d_wdata = ~w; d_we = ~we; end
        else begin if_req = 0; if_addr = ~a; end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, mem_en, mem_we, if_ack, d_ack} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctl: got %b expected 00000", {busy, mem_en, mem_we, if_ack, d_ack});
    end
    n_vec++;
    if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 256'b0) begin
      n_err++; $display("FAIL reset_data: got %h %h %h %h expected all zero", if_rdata, d_rdata, mem_addr, mem_wdata);
    end
    apply_reset();
  endtask

  task automatic test_single_fetch();
    int en_c, ack_c, n_en, n_ack, n_oth, busy_n;
    logic en_we;
    logic [63:0] ea, ew, rd;
    mem[64'h0] = 64'h00500093;
    run_txn(0, 0, 64'h0, 64'h0, 0, en_c, ack_c, n_en, n_ack, n_oth, busy_n, en_we, ea, ew, rd);
    n_vec++; if (en_c !== 1) begin n_err++; $display("FAIL fetch_en_cycle: got %0d expected 1", en_c); end
    n_vec++; if (en_we !== 1'b0 || ea !== 64'h0) begin n_err++; $display("FAIL fetch_mem: got we=%b addr=%h expected we=0 addr=0", en_we, ea); end
    n_vec++; if (ack_c !== LAT + 2) begin n_err++; $display("FAIL fetch_ack_cycle: got %0d expected %0d", ack_c, LAT + 2); end
    n_vec++; if (rd !== 64'h00500093) begin n_err++; $display("FAIL fetch_rdata: got %h expected 00500093", rd); end
    n_vec++; if (busy_n !== LAT + 1 || n_ack !== 1 || n_en !== 1 || n_oth !== 0) begin
      n_err++; $display("FAIL fetch_counts: got busy=%0d ack=%0d en=%0d oth=%0d expected %0d 1 1 0", busy_n, n_ack, n_en, n_oth, LAT + 1);
    end
  endtask

  task automatic test_store_load();
    int en_c, ack_c, n_en, n_ack, n_oth, busy_n;
    logic en_we;
    logic [63:0] ea, ew, rd, prev;
    prev = d_rdata;
    run_txn(1, 1, 64'h100, 64'hDEADBEEF, 0, en_c, ack_c, n_en, n_ack, n_oth, busy_n, en_we, ea, ew, rd);
    n_vec++; if (en_we !== 1'b1 || ea !== 64'h100 || ew !== 64'hDEADBEEF) begin
      n_err++; $display("FAIL store_mem: got we=%b addr=%h wdata=%h expected 1 100 deadbeef", en_we, ea, ew);
    end
    n_vec++; if (ack_c !== LAT + 2 || n_ack !== 1) begin n_err++; $display("FAIL store_ack: got cycle %0d count %0d expected %0d 1", ack_c, n_ack, LAT + 2); end
    n_vec++; if (rd !== prev) begin n_err++; $display("FAIL store_rdata_hold: got %h expected %h", rd, prev); end
    run_txn(1, 0, 64'h100, 64'h0, 0, en_c, ack_c, n_en, n_ack, n_oth, busy_n, en_we, ea, ew, rd);
    n_vec++; if (en_we !== 1'b0 || ea !== 64'h100) begin n_err++; $display("FAIL load_mem: got we=%b addr=%h expected 0 100", en_we, ea); end
    n_vec++; if (ack_c !== LAT + 2) begin n_err++; $display("FAIL load_ack_cycle: got %0d expected %0d", ack_c, LAT + 2); end
    n_vec++; if (rd !== 64'hDEADBEEF) begin n_err++; $display("FAIL load_rdata: got %h expected deadbeef", rd); end
  endtask

  task automatic test_collision();
    int na, n_en, dbl;
    logic [3:0] order;
    apply_reset();
    na = 0; n_en = 0; dbl = 0; order = '0;
    if_req = 1; if_addr = 64'h20; d_req = 1; d_we = 0; d_addr = 64'h28;
    for (int k = 0; k < 40 && na < 4; k++) begin
      @(negedge clk);
      if (mem_en) n_en++;
      if (if_ack && d_ack) dbl++;
      if (d_ack || if_ack) begin
        order = {order[2:0], d_ack};
        na++;
        if (na == 4) begin if_req = 0; d_req = 0; end
      end
    end
    repeat (6) begin
      @(negedge clk);
      if (mem_en) n_en++;
    end
    n_vec++; if (order !== 4'b1010 || na !== 4) begin n_err++; $display("FAIL collide_order: got %b (%0d acks) expected 1010 (4)", order, na); end
    n_vec++; if (n_en !== 4) begin n_err++; $display("FAIL collide_mem_en: got %0d expected 4", n_en); end
    n_vec++; if (dbl !== 0) begin n_err++; $display("FAIL collide_double_ack: got %0d expected 0", dbl); end
  endtask

  task automatic test_withdraw();
    int en_c, ack_c, n_en, n_ack, n_oth, busy_n;
    logic en_we;
    logic [63:0] ea, ew, rd;
    mem[64'h18] = 64'h0123456789ABCDEF;
    run_txn(1, 0, 64'h18, 64'h0, 1, en_c, ack_c, n_en, n_ack, n_oth, busy_n, en_we, ea, ew, rd);
    n_vec++; if (n_ack !== 1 || ack_c !== LAT + 2) begin n_err++; $display("FAIL withdraw_ack: got count %0d cycle %0d expected 1 %0d", n_ack, ack_c, LAT + 2); end
    n_vec++; if (rd !== 64'h0123456789ABCDEF || n_en !== 1) begin n_err++; $display("FAIL withdraw_data: got %h en=%0d expected 0123456789abcdef en=1", rd, n_en); end
  endtask

  task automatic test_reset_mid();
    int en_c, ack_c, n_en, n_ack, n_oth, busy_n, stray;
    logic en_we;
    logic [63:0] ea, ew, rd;
    mem[64'h30] = 64'hCAFEF00D12345678;
    @(negedge clk); if_req = 1; if_addr = 64'h30;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0; if_req = 0;
    #1;
    n_vec++; if ({busy, mem_en, if_ack, d_ack} !== 4'b0 || if_rdata !== 64'h0) begin
      n_err++; $display("FAIL midreset_outputs: got ctl=%b rdata=%h expected 0000 0", {busy, mem_en, if_ack, d_ack}, if_rdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (6) begin @(negedge clk); if (if_ack || d_ack || mem_en) stray++; end
    n_vec++; if (stray !== 0) begin n_err++; $display("FAIL midreset_no_ack: got %0d stray events expected 0", stray); end
    run_txn(0, 0, 64'h30, 64'h0, 0, en_c, ack_c, n_en, n_ack, n_oth, busy_n, en_we, ea, ew, rd);
    n_vec++; if (ack_c !== LAT + 2 || rd !== 64'hCAFEF00D12345678) begin
      n_err++; $display("FAIL midreset_refetch: got cycle %0d data %h expected %0d cafef00d12345678", ack_c, rd, LAT + 2);
    end
  endtask

  task automatic test_lat1();
    int ack_c, n_ack, busy_n;
    logic [63:0] rd;
    ack_c = -1; n_ack = 0; busy_n = 0; rd = 'x;
    @(negedge clk); if_req1 = 1; if_addr1 = 64'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (busy1) busy_n++;
      if (if_ack1) begin n_ack++; ack_c = k; rd = if_rdata1; if_req1 = 0; end
    end
    n_vec++; if (ack_c !== 3 || n_ack !== 1) begin n_err++; $display("FAIL lat1_ack: got cycle %0d count %0d expected 3 1", ack_c, n_ack); end
    n_vec++; if (rd !== 64'h00500093 || busy_n !== 2) begin n_err++; $display("FAIL lat1_data: got %h busy=%0d expected 00500093 2", rd, busy_n); end
  endtask

  task automatic test_random();
    int gnt_t, free_t;
    logic tv, own, twe, last_f, sel;
    logic [63:0] taddr, twdata, tdata, ex_if, ex_d, v;
    logic pend_f, pend_d, e_af, e_ad, e_en, e_busy, ef, ed, fly_f, fly_d;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      v = {$urandom, $urandom}; mem[64'(i) << 3] = v; refmem[i] = v;
    end
    gnt_t = -100; free_t = 0; tv = 0; own = 0; twe = 0; last_f = 1;
    taddr = '0; twdata = '0; tdata = '0; ex_if = '0; ex_d = '0; pend_f = 0; pend_d = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      e_af   = tv && k == free_t && !own;
      e_ad   = tv && k == free_t && own;
      e_en   = tv && k == gnt_t + 1;
      e_busy = tv && k > gnt_t && k < free_t;
      if (e_af) ex_if = tdata;
      if (e_ad && !twe) ex_d = tdata;
      n_vec++; if (if_ack !== e_af) begin n_err++; $display("FAIL rnd_if_ack: cycle %0d got %b expected %b", k, if_ack, e_af); end
      n_vec++; if (d_ack !== e_ad) begin n_err++; $display("FAIL rnd_d_ack: cycle %0d got %b expected %b", k, d_ack, e_ad); end
      n_vec++; if (busy !== e_busy) begin n_err++; $display("FAIL rnd_busy: cycle %0d got %b expected %b", k, busy, e_busy); end
      n_vec++; if (mem_en !== e_en) begin n_err++; $display("FAIL rnd_mem_en: cycle %0d got %b expected %b", k, mem_en, e_en); end
      n_vec++; if (if_rdata !== ex_if) begin n_err++; $display("FAIL rnd_if_rdata: cycle %0d got %h expected %h", k, if_rdata, ex_if); end
      n_vec++; if (d_rdata !== ex_d) begin n_err++; $display("FAIL rnd_d_rdata: cycle %0d got %h expected %h", k, d_rdata, ex_d); end
      if (e_en) begin
        n_vec++;
        if (mem_we !== twe || mem_addr !== taddr || (twe && mem_wdata !== twdata)) begin
          n_err++; $display("FAIL rnd_mem_access: cycle %0d got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                            k, mem_we, mem_addr, mem_wdata, twe, taddr, twdata);
        end
      end
      if (e_af) pend_f = 0;
      if (e_ad) pend_d = 0;
      fly_f = e_busy && !own;
      fly_d = e_busy && own;
      if (e_af) begin
        if ($urandom_range(0, 1) == 0) if_req = 0;
        else begin if_req = 1; if_addr = 64'($urandom_range(0, 7)) << 3; pend_f = 1; end
      end else if (!if_req && !pend_f && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = 64'($urandom_range(0, 7)) << 3; pend_f = 1;
      end else if (fly_f && $urandom_range(0, 3) == 0) begin
        if_req = 0; if_addr = {$urandom, $urandom};
      end
      if (e_ad) begin
        if ($urandom_range(0, 1) == 0) d_req = 0;
        else begin
          d_req = 1; d_we = $urandom_range(0, 1) == 1; d_addr = 64'($urandom_range(0, 7)) << 3;
          d_wdata = {$urandom, $urandom}; pend_d = 1;
        end
      end else if (!d_req && !pend_d && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = $urandom_range(0, 1) == 1; d_addr = 64'($urandom_range(0, 7)) << 3;
        d_wdata = {$urandom, $urandom}; pend_d = 1;
      end else if (fly_d && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) d_req = 0;
        d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom}; d_we = ~d_we;
      end
      if (k >= free_t) begin
        ef = if_req && !e_af;
        ed = d_req && !e_ad;
        if (ef || ed) begin
          sel = ed && (!ef || last_f);
          tv = 1; own = sel; last_f = !sel; gnt_t = k; free_t = k + LAT + 2;
          twe = sel && d_we;
          taddr = sel ? d_addr : if_addr;
          twdata = d_wdata;
          if (twe) refmem[taddr[5:3]] = twdata;
          else tdata = refmem[taddr[5:3]];
        end
      end
    end
    if_req = 0; d_req = 0;
    repeat (LAT + 4) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    if_req1 = 0; if_addr1 = '0; d_req1 = 0; d_we1 = 0; d_addr1 = '0; d_wdata1 = '0;
    en1_prev = 0; mem_rdata1 = '0;
    test_reset();
    test_single_fetch();
    test_store_load();
    test_withdraw();
    test_reset_mid();
    test_lat1();
    test_collision();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
